dmem_dump: RTL
==============

Name: dmem_dump

Overview:
- 64-bit data memory directly downstream of processor_arm; consumes its DM_writeData, DM_addr and DM_writeEnable, and returns read data.
- Adds a dump sequencer: on a rising edge of `dump`, streams every memory word out over a valid/ready port, then signals completion.
- Lets the bench check final memory state after a program run without hierarchical peeking.

Parameters:
- N, 64, data and address width in bits.
- DEPTH, 64, number of N-bit words; power of two.
- IDX_W, $clog2(DEPTH), word index width (derived; do not override).

Ports:
- CLOCK_50  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- DM_writeEnable  input  1  store strobe from processor.
- DM_readEnable  input  1  load strobe from processor.
- DM_addr  input  N  byte address; word index = DM_addr[IDX_W+2:3].
- DM_writeData  input  N  store data.
- DM_readData  output  N  load data.
- dump  input  1  dump request; level signal, edge-detected internally.
- dump_ready  input  1  sink accepts the current dump beat.
- dump_valid  output  1  dump beat present.
- dump_addr  output  N  byte address of the presented word (index*8).
- dump_data  output  N  contents of the presented word.
- dump_done  output  1  all words emitted.
- busy  output  1  dump in progress; stores are blocked.

Behaviour:
- Reset: all DEPTH words become 0. FSM goes to IDLE; ptr=0; dump_prev=0. dump_valid, dump_done and busy = 0; dump_addr and dump_data = 0.
- Address: bits [2:0] and bits above IDX_W+2 are ignored; addresses wrap modulo DEPTH*8.
- Read: combinational. DM_readData = mem[idx] when DM_readEnable=1, else 0.
- Write: synchronous. mem[idx] <= DM_writeData on a clock edge where DM_writeEnable=1, busy=0 and reset=0. A read of the same word in the write cycle returns the old value.
- FSM states IDLE, RUN, DONE.
  - dump_prev <= dump every cycle. rise = dump & ~dump_prev.
  - dump held high across reset release counts as a rise on the first cycle after reset.
- IDLE:
  - On rise: go to RUN, ptr <= 0.
  - Other outputs 0.
- RUN:
  - busy=1, dump_valid=1, dump_addr={ptr,3'b000} zero-extended, dump_data=mem[ptr].
  - Beat accepted when dump_valid & dump_ready.
    - Accepted and ptr != DEPTH-1: ptr <= ptr+1.
    - Accepted and ptr == DEPTH-1: go to DONE.
  - If dump_ready=0: hold ptr; dump_addr and dump_data stay stable.
  - Stores are dropped while busy=1, so the presented data cannot change.
  - Further rises on `dump` are ignored.
- DONE:
  - dump_done=1, busy=0, dump_valid=0; stores re-enabled.
  - When dump=0: go to IDLE.
- Latency: rise sampled at edge t gives dump_valid=1 from cycle t+1. With dump_ready tied 1, word k is presented in cycle t+1+k. dump_done=1 from cycle t+1+DEPTH.
- Reset mid-dump: immediate return to IDLE, memory cleared, outputs 0 the next cycle.
- Simultaneous store and rise in IDLE: the store commits (busy is still 0); the dump then starts and sees the new value.

Optional Feature:
- Macro: DMEM_DUMP_SKIP_ZERO_EN.
- Defined:
  - In RUN, a word equal to 0 is not presented (dump_valid=0).
  - ptr advances one word per cycle, with no handshake, over zero words.
  - The FSM enters DONE after index DEPTH-1 is either accepted or skipped.
  - An all-zero memory reaches DONE DEPTH cycles after RUN entry with no beats.
- Undefined: every word is emitted, as specified above.

Decomposition:
- Package dmem_pkg holds:
  - localparams WORD_BYTES=8 and BYTE_SHIFT=3;
  - typedef enum logic [1:0] {IDLE, RUN, DONE} dump_state_t;
  - function word_idx(addr) returning the IDX_W-bit index.
- Sub-module dmem_dump_fsm holds the edge detector, the state register and ptr. It outputs ptr, dump_valid, dump_done and busy.
- The top holds the storage array, the read mux and the write gating.

Test Plan:
- Store/load: write 0xDEADBEEF00000001 at addr 0x18, then readEnable addr 0x18 → readData 0xDEADBEEF00000001. Addr 0x218 (DEPTH=64) aliases → same value.
- Full dump with ready=1:
  - preload mem[0]=5 and mem[63]=7, pulse dump;
  - 64 consecutive beats, beat 0 {addr 0x0, data 5}, beat 63 {addr 0x1F8, data 7};
  - dump_done asserted the cycle after beat 63.
- Backpressure: ready=0 for 3 cycles at beat 10 → addr 0x50 and its data held stable for 3 cycles with valid=1; ptr resumes on ready=1; total still 64 beats.
- Store blocked: DM_writeEnable=1 to addr 0x0 with data 9 while busy → mem[0] unchanged after the dump. The same store after dump_done commits.
- Reset mid-dump: assert reset at beat 20 → next cycle valid=0, busy=0, mem[20] reads 0. A new dump rise restarts from addr 0x0.
- Skip-zero (macro defined): only mem[3]=1 and mem[40]=2 nonzero → exactly 2 beats, at 0x18 and 0x140; dump_done at RUN entry+64 cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_dump data memory and its dump sequencer.
package dmem_pkg;

  localparam int WORD_BYTES = 8;
  localparam int BYTE_SHIFT = 3;

  localparam int DMEM_N     = 64;
  localparam int DMEM_DEPTH = 64;
  localparam int DMEM_IDX_W = $clog2(DMEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } dump_state_t;

  function automatic logic [DMEM_IDX_W-1:0] word_idx(input logic [DMEM_N-1:0] addr);
    return addr[BYTE_SHIFT +: DMEM_IDX_W];
  endfunction

endpackage

// File: rtl/dmem_dump_fsm.sv
// Dump sequencer: edge-detects dump, walks ptr across the memory under valid/ready.
// With DMEM_DUMP_SKIP_ZERO_EN defined, zero words are stepped over without a beat.
module dmem_dump_fsm
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dump,
  input  logic             dump_ready,
`ifdef DMEM_DUMP_SKIP_ZERO_EN
  input  logic             word_zero,
`endif
  output logic [IDX_W-1:0] ptr,
  output logic             dump_valid,
  output logic             dump_done,
  output logic             busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  dump_state_t      state;
  dump_state_t      state_next;
  logic [IDX_W-1:0] ptr_next;
  logic             dump_prev;
  logic             rise;
  logic             advance;

  // dump_prev clears on reset so a level held through reset release starts a dump
  assign rise = dump & ~dump_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      dump_prev <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      dump_prev <= dump;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    dump_valid = 1'b0;
    dump_done  = 1'b0;
    busy       = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_next = RUN;
          ptr_next   = '0;
        end
      end
      RUN: begin
        busy = 1'b1;
`ifdef DMEM_DUMP_SKIP_ZERO_EN
        dump_valid = ~word_zero;
        advance    = word_zero | dump_ready;
`else
        dump_valid = 1'b1;
        advance    = dump_ready;
`endif
        if (advance) begin
          if (ptr == LAST_IDX) state_next = DONE;
          else                 ptr_next   = ptr + 1'b1;
        end
      end
      DONE: begin
        dump_done = 1'b1;
        if (!dump) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/dmem_dump.sv
// 64-bit data memory with combinational loads, gated stores and a streaming dump port.
// Build option DMEM_DUMP_SKIP_ZERO_EN suppresses beats for all-zero words.
module dmem_dump
  import dmem_pkg::*;
#(
  parameter int N     = 64,
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         DM_writeEnable,
  input  logic         DM_readEnable,
  input  logic [N-1:0] DM_addr,
  input  logic [N-1:0] DM_writeData,
  output logic [N-1:0] DM_readData,
  input  logic         dump,
  input  logic         dump_ready,
  output logic         dump_valid,
  output logic [N-1:0] dump_addr,
  output logic [N-1:0] dump_data,
  output logic         dump_done,
  output logic         busy
);

  logic [N-1:0]     mem [DEPTH];
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] ptr;
  logic             store;

  // Byte offset and anything above the array are dropped, so addresses alias modulo DEPTH*8
  assign idx   = DM_addr[BYTE_SHIFT +: IDX_W];
  assign store = DM_writeEnable & ~busy;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (store) begin
      mem[idx] <= DM_writeData;
    end
  end

  assign DM_readData = DM_readEnable ? mem[idx] : '0;

  dmem_dump_fsm #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_fsm (
    .clk        (CLOCK_50),
    .rst        (reset),
    .dump       (dump),
    .dump_ready (dump_ready),
`ifdef DMEM_DUMP_SKIP_ZERO_EN
    .word_zero  (mem[ptr] == '0),
`endif
    .ptr        (ptr),
    .dump_valid (dump_valid),
    .dump_done  (dump_done),
    .busy       (busy)
  );

  // Stores are blocked while busy, so the presented word is stable under backpressure
  assign dump_addr = busy ? {{(N-IDX_W-BYTE_SHIFT){1'b0}}, ptr, {BYTE_SHIFT{1'b0}}} : '0;
  assign dump_data = busy ? mem[ptr] : '0;

endmodule
